// File: rtl/ov7670_pkg.sv
// Shared types and table markers for the OV7670 configuration sequencer.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DELAY     = 3'd4,
    ST_DONE      = 3'd5
  } seq_state_e;

  localparam logic [15:0] TBL_END   = 16'hFFFF;
  localparam logic [15:0] TBL_DELAY = 16'hFFF0;

  function automatic logic is_write(input logic [15:0] entry);
    return (entry != TBL_END) && (entry != TBL_DELAY);
  endfunction

endpackage

// File: rtl/ov7670_config_rom.sv
// OV7670 register table: {reg_addr, reg_data} per entry, FFF0 = wait, FFFF = end.
module ov7670_config_rom
  import ov7670_pkg::*;
#(
  parameter int ROM_AW = 8
) (
  input  logic [ROM_AW-1:0] addr,
  output logic [15:0]       data
);

  // Combinational lookup; unlisted indices read as the end marker.
  always_comb begin
    data = TBL_END;
    case (addr)
      ROM_AW'(0):  data = 16'h1280;
      ROM_AW'(1):  data = TBL_DELAY;
      ROM_AW'(2):  data = 16'h1204;
      ROM_AW'(3):  data = 16'h1101;
      ROM_AW'(4):  data = 16'h0C00;
      ROM_AW'(5):  data = 16'h3E00;
      ROM_AW'(6):  data = 16'h0400;
      ROM_AW'(7):  data = 16'h40D0;
      ROM_AW'(8):  data = 16'h3A04;
      ROM_AW'(9):  data = 16'h1418;
      ROM_AW'(10): data = 16'h4FB3;
      ROM_AW'(11): data = 16'h50B3;
      ROM_AW'(12): data = 16'h5100;
      ROM_AW'(13): data = 16'h523D;
      ROM_AW'(14): data = 16'h53A7;
      ROM_AW'(15): data = 16'h54E4;
      ROM_AW'(16): data = 16'h589E;
      ROM_AW'(17): data = 16'h3DC0;
      ROM_AW'(18): data = 16'h1714;
      ROM_AW'(19): data = 16'h1802;
      ROM_AW'(20): data = 16'h3280;
      ROM_AW'(21): data = 16'h1903;
      ROM_AW'(22): data = 16'h1A7B;
      ROM_AW'(23): data = 16'h030A;
      ROM_AW'(24): data = 16'h0F41;
      ROM_AW'(25): data = 16'h1E00;
      ROM_AW'(26): data = 16'h330B;
      ROM_AW'(27): data = 16'h3C78;
      ROM_AW'(28): data = 16'h6900;
      ROM_AW'(29): data = 16'h7400;
      ROM_AW'(30): data = 16'hB084;
      ROM_AW'(31): data = 16'hB10C;
      ROM_AW'(32): data = 16'hB20E;
      ROM_AW'(33): data = 16'hB380;
      ROM_AW'(34): data = 16'h703A;
      ROM_AW'(35): data = 16'h7135;
      ROM_AW'(36): data = 16'h7211;
      ROM_AW'(37): data = 16'h73F0;
      ROM_AW'(38): data = 16'hA202;
      default:     data = TBL_END;
    endcase
  end

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the configuration table, issuing one SCCB write per entry and
// honouring delay/end markers; done is held until restart or reset.
module ov7670_config_sequencer
  import ov7670_pkg::*;
#(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int DELAY_CYCLES = CLK_FREQ / 100,
  parameter int ROM_AW       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        SCCB_addr,
  output logic [7:0]        SCCB_data,
  output logic              SCCB_start,
  input  logic              SCCB_ready
);

  localparam logic [ROM_AW-1:0] LAST_ADDR    = {ROM_AW{1'b1}};
  localparam logic [31:0]       DELAY_RELOAD = 32'(DELAY_CYCLES - 1);

  seq_state_e  state_r;
  logic [31:0] timer_r;
  logic        last_r;   // delay marker sat at the final index: finish after it

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      rom_addr   <= '0;
      SCCB_addr  <= 8'h00;
      SCCB_data  <= 8'h00;
      SCCB_start <= 1'b0;
      done       <= 1'b0;
      timer_r    <= 32'd0;
      last_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            rom_addr <= '0;
            done     <= 1'b0;
            state_r  <= ST_FETCH;
          end else begin
            state_r <= state_r;
          end
        end
        ST_FETCH: begin
          if (rom_data == TBL_END) begin
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else if (rom_data == TBL_DELAY) begin
            timer_r <= DELAY_RELOAD;
            if (rom_addr == LAST_ADDR) begin
              last_r <= 1'b1;
            end else begin
              last_r   <= 1'b0;
              rom_addr <= rom_addr + 1'b1;
            end
            state_r <= ST_DELAY;
          end else if (is_write(rom_data) && SCCB_ready) begin
            SCCB_addr  <= rom_data[15:8];
            SCCB_data  <= rom_data[7:0];
            SCCB_start <= 1'b1;
            state_r    <= ST_WAIT_BUSY;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_WAIT_BUSY: begin
          SCCB_start <= 1'b0;
          if (!SCCB_ready) begin
            state_r <= ST_WAIT_DONE;
          end else begin
            state_r <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_DONE: begin
          if (SCCB_ready) begin
            if (rom_addr == LAST_ADDR) begin
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              state_r  <= ST_FETCH;
            end
          end else begin
            state_r <= ST_WAIT_DONE;
          end
        end
        ST_DELAY: begin
          if (timer_r == 32'd0) begin
            if (last_r) begin
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_FETCH;
            end
          end else begin
            timer_r <= timer_r - 32'd1;
          end
        end
        default: begin
          SCCB_start <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
